les_decrypt: RTL

Iterative LES block decryptor: the receive-side counterpart of `les_top`. It takes a 32-bit ciphertext, runs the LES Feistel network in reverse round order at one round per clock, and presents the recovered 32-bit plaintext. It sits beside `les_top` in the test tops so the board can close the encrypt→decrypt loop. Its control handshake matches `les_top`: `clr`, `start`, `busy`, plus a `done` pulse.

---
 rtl/les_pkg.sv | 26 ++
 rtl/les_round.sv | 15 +
 rtl/les_decrypt.sv | 76 +++++++
 3 files changed

// File: rtl/les_pkg.sv
// rtl/les_pkg.sv - shared LES cipher constants, round key and round function
package les_pkg;

  localparam int          LES_ROUNDS = 8;
  localparam logic [31:0] LES_KEY    = 32'hACE1_0F0F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } les_state_t;

  function automatic logic [15:0] les_round_key(input logic [31:0] key, input logic [3:0] i);
    logic [15:0] half;
    half = i[0] ? key[15:0] : key[31:16];
    return half ^ {12'b0, i};
  endfunction

  function automatic logic [15:0] les_f(input logic [15:0] r, input logic [15:0] k);
    logic [15:0] rotl3;
    logic [15:0] rotr5;
    rotl3 = {r[12:0], r[15:13]};
    rotr5 = {r[4:0], r[15:5]};
    return (rotl3 ^ k) + rotr5;
  endfunction

endpackage

// File: rtl/les_round.sv
// rtl/les_round.sv - one combinational LES decrypt round
module les_round
  import les_pkg::*;
(
  input  logic [15:0] l,
  input  logic [15:0] r,
  input  logic [15:0] k,
  output logic [15:0] l_next,
  output logic [15:0] r_next
);

  assign r_next = l;
  assign l_next = r ^ les_f(l, k);

endmodule

// File: rtl/les_decrypt.sv
// rtl/les_decrypt.sv - iterative LES decryptor, one reverse round per clock
module les_decrypt
  import les_pkg::*;
#(
  parameter int          ROUNDS = LES_ROUNDS,
  parameter logic [31:0] KEY    = LES_KEY
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] cipher_in,
  output logic [31:0] text_out,
  output logic        busy,
  output logic        done
);

  les_state_t  state;
  logic [3:0]  idx;
  logic [15:0] l, r, k, l_next, r_next;

  assign k = les_round_key(KEY, idx);

  les_round u_round (
    .l      (l),
    .r      (r),
    .k      (k),
    .l_next (l_next),
    .r_next (r_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      idx      <= '0;
      l        <= '0;
      r        <= '0;
      text_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        text_out <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              l     <= cipher_in[31:16];
              r     <= cipher_in[15:0];
              idx   <= 4'(ROUNDS - 1);
              busy  <= 1'b1;
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            l   <= l_next;
            r   <= r_next;
            idx <= idx - 4'd1;
            // Round 0 is the last one applied; its output is the plaintext.
            if (idx == 4'd0) begin
              text_out <= {l_next, r_next};
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
